seven_segment_decoder: RTL

Recovers hex digits from a multiplexed, active-high seven-segment drive bus (segment byte plus active-low digit enables) and presents each completed scan frame as a hex word over a valid/ready handshake. It is the inverse of the hex-to-segment encoder. It sits on the receive side of board-to-board links, and in loopback checks where one FPGA's display pins are wired into another FPGA's inputs.

---
 rtl/seven_segment_decoder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
// Recovers hex digits from a multiplexed, active-high seven-segment drive bus
// and presents each completed scan frame as a hex word over valid/ready.
//
// Parameters:
//   DIGITS        number of multiplexed digits (1..8)
//   STABLE_CYCLES identical synchronized samples required before a capture (>=2)
// Ports:
//   clk, reset    sole clock; asynchronous active-high reset
//   seg[7:0]      {a,b,c,d,e,f,g,dp}, active-high, asynchronous to clk
//   an            digit enables, active-low, asynchronous to clk
//   out_digits    captured frame, digit k in bits [4k+3:4k]
//   out_dp        decimal point per digit (0 unless SEG_DECODE_DP_EN)
//   out_err       per digit: captured pattern was not a legal hex glyph
//   out_valid     frame held in the output register
//   out_ready     consumer accepts the frame when high with out_valid
//   overrun       sticky: a completed frame was dropped
// Build option:
//   SEG_DECODE_DP_EN  define to capture dp per slot and drive out_dp
module seven_segment_decoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   out_digits,
  output logic [DIGITS-1:0]     out_dp,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun
);

  localparam int unsigned CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Synchronizers, previous-sample copy and stability tracking
  logic [7:0]              seg_m_q, seg_s_q, seg_p_q;
  logic [DIGITS-1:0]       an_m_q, an_s_q, an_p_q;
  logic [CW-1:0]           cnt_q;
  logic                    fired_q;

  // Per-digit slots and the mask of slots filled in the current frame
  logic [DIGITS-1:0][3:0]  slot_nib_q;
  logic [DIGITS-1:0]       slot_err_q;
  logic [DIGITS-1:0]       seen_q;

  logic                    changed_c, hit_c, capture_c;
  logic                    frame_done_c, load_c, drop_c;
  int unsigned             nz_c;
  logic [IW-1:0]           idx_c;
  logic [3:0]              nib_c;
  logic                    err_c;

  assign changed_c = (seg_s_q != seg_p_q) || (an_s_q != an_p_q);
  // One stability hit per stable period; fired_q blocks repeats until s changes
  assign hit_c     = !changed_c && (cnt_q == CNT_MAX) && !fired_q;
  assign capture_c = hit_c && (nz_c == 1);

  assign frame_done_c = &seen_q;
  assign load_c       = frame_done_c && (!out_valid || out_ready);
  assign drop_c       = frame_done_c && !load_c;

  // Count low enables and locate the active digit
  always_comb begin
    nz_c  = 0;
    idx_c = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (!an_s_q[k]) begin
        nz_c  = nz_c + 1;
        idx_c = IW'(k);
      end
    end
  end

  // Glyph decode on {a..g}
  always_comb begin
    nib_c = 4'h0;
    err_c = 1'b0;
    case (seg_s_q[7:1])
      7'b1111110: nib_c = 4'h0;
      7'b0110000: nib_c = 4'h1;
      7'b1101101: nib_c = 4'h2;
      7'b1111001: nib_c = 4'h3;
      7'b0110011: nib_c = 4'h4;
      7'b1011011: nib_c = 4'h5;
      7'b1011111: nib_c = 4'h6;
      7'b1110000: nib_c = 4'h7;
      7'b1111111: nib_c = 4'h8;
      7'b1111011: nib_c = 4'h9;
      7'b1110111: nib_c = 4'hA;
      7'b0011111: nib_c = 4'hB;
      7'b1001110: nib_c = 4'hC;
      7'b0111101: nib_c = 4'hD;
      7'b1001111: nib_c = 4'hE;
      7'b1000111: nib_c = 4'hF;
      default: begin
        nib_c = 4'h0;
        err_c = 1'b1;
      end
    endcase
  end

  // Input synchronizers and stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_m_q <= '0;
      seg_s_q <= '0;
      seg_p_q <= '0;
      an_m_q  <= '0;
      an_s_q  <= '0;
      an_p_q  <= '0;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      seg_m_q <= seg;
      seg_s_q <= seg_m_q;
      seg_p_q <= seg_s_q;
      an_m_q  <= an;
      an_s_q  <= an_m_q;
      an_p_q  <= an_s_q;
      if (changed_c) begin
        cnt_q   <= '0;
        fired_q <= 1'b0;
      end else if (hit_c) begin
        fired_q <= 1'b1;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  // Slot capture and frame assembly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_nib_q <= '0;
      slot_err_q <= '0;
      seen_q     <= '0;
    end else begin
      if (frame_done_c) begin
        seen_q <= '0;
      end else if (capture_c) begin
        seen_q[idx_c] <= 1'b1;
      end
      if (capture_c) begin
        slot_nib_q[idx_c] <= nib_c;
        slot_err_q[idx_c] <= err_c;
      end
    end
  end

  // Output register and handshake; a load beats a simultaneous accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_digits <= '0;
      out_err    <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load_c) begin
        out_digits <= slot_nib_q;
        out_err    <= slot_err_q;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef SEG_DECODE_DP_EN
  // Decimal-point slots and output
  logic [DIGITS-1:0] slot_dp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_dp_q <= '0;
      out_dp    <= '0;
    end else begin
      if (capture_c) begin
        slot_dp_q[idx_c] <= seg_s_q[0];
      end
      if (load_c) begin
        out_dp <= slot_dp_q;
      end
    end
  end
`else
  assign out_dp = '0;
`endif

endmodule
